axi_lite_write_arbiter: RTL and testbench
=========================================

// Module: axi_lite_write_arbiter
// PURPOSE
// - Shares one AXI4-Lite write port (AW/W/B) between NUM_REQ local requesters.
// - Arbitration is round-robin, one transaction in flight at a time.
// - Sits upstream of the AXI-Lite write register slave and sequences config writes from several engines.
// - Each requester sees a simple req/ready + rsp_valid/rsp_resp interface, not the AXI protocol.
// PARAMETERS
// - NUM_REQ         2    number of requesters, 2..8
// - ADDRESS_SIZE    32   AXI address width
// - DATA_SIZE       32   AXI data width, multiple of 8
// - TIMEOUT_CYCLES  256  watchdog limit; used only with AXIL_WR_TIMEOUT_EN
// PORTS
// - aclk         in   1                   clock, all logic on rising edge
// - aresetn      in   1                   reset, synchronous, active-low
// - req_valid    in   NUM_REQ             requester i has a pending write
// - req_addr     in   NUM_REQ*ADDRESS_SIZE  requester i address, slice [i*A +: A]
// - req_data     in   NUM_REQ*DATA_SIZE   requester i write data
// - req_strb     in   NUM_REQ*DATA_SIZE/8 requester i byte strobes
// - req_ready    out  NUM_REQ             one-cycle pulse: request i captured
// - rsp_valid    out  NUM_REQ             one-cycle pulse: write i complete
// - rsp_resp     out  2                   response code, valid with any rsp_valid bit
// - m_awaddr     out  ADDRESS_SIZE        AXI write address
// - m_awvalid    out  1                   AXI write address valid
// - m_awready    in   1                   AXI write address ready
// - m_wdata      out  DATA_SIZE           AXI write data
// - m_wstrb      out  DATA_SIZE/8         AXI write strobes
// - m_wvalid     out  1                   AXI write data valid
// - m_wready     in   1                   AXI write data ready
// - m_bresp      in   2                   AXI write response
// - m_bvalid     in   1                   AXI write response valid
// - m_bready     out  1                   AXI write response ready
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; round-robin pointer rr=0.
//   aresetn low mid-transaction aborts it immediately; no rsp_valid is issued.
// - IDLE:
//   - Grant g = first i with req_valid[i], searching rr, rr+1, ... modulo NUM_REQ.
//   - Same cycle: pulse req_ready[g]; register addr/data/strb of g; -> ISSUE.
//   - No req_valid set: stay in IDLE.
// - ISSUE:
//   - m_awvalid and m_wvalid are asserted the cycle after the grant.
//   - Each drops independently on its own handshake (valid&&ready). AW and W may complete in either order or together.
//   - When both are done -> WAIT_B. m_bready=1 from the cycle both are done.
//   - AXI payload is stable while its valid is high.
// - WAIT_B:
//   - On m_bvalid&&m_bready: latch m_bresp to rsp_resp; m_bready<=0; pulse rsp_valid[g] next cycle.
//   - Set rr=(g+1)%NUM_REQ (wrap at NUM_REQ-1 -> 0); -> IDLE.
// - Latency: 0 stall cycles -> grant to rsp_valid = 3 cycles (grant, AW/W, B, rsp). Back-to-back grants allowed in the rsp_valid cycle.
// - rsp_resp holds its value until the next response; m_bresp passes through unmodified (00 OKAY, 10 SLVERR, etc.).
// - Requesters must hold req_* stable until req_ready; capture makes later changes harmless.
// - A requester whose req_valid drops before grant is skipped; no phantom transaction.
// - Fairness: a continuously requesting set is served strictly in rotation; no requester waits more than NUM_REQ-1 transactions.
// CONFIGURATION
// - AXIL_WR_TIMEOUT_EN defined:
//   - Counter runs in ISSUE and WAIT_B; cleared on entering ISSUE.
//   - Reaching TIMEOUT_CYCLES forces m_awvalid/m_wvalid/m_bready low and sets rsp_resp=2'b11 (DECERR).
//   - Then pulses rsp_valid[g], advances rr and returns to IDLE (fault recovery, deliberate AXI exception).
//   - A late m_bvalid arriving in IDLE is ignored.
// - AXIL_WR_TIMEOUT_EN undefined: no counter; arbiter waits indefinitely.
// TESTING
// - Single write: req_valid=01, addr0=0x0, data0=0xDEADBEEF, strb=F; slave ready=1, bresp=00
//     -> AW/W one cycle, rsp_valid=01, rsp_resp=00 at cycle 3.
// - Contention: req_valid=11 held, rr=0 -> grant order 0,1,0,1; each req_ready pulse once per transaction.
// - Skewed handshake: m_wready high 4 cycles before m_awready
//     -> wvalid drops first, awvalid held with stable awaddr, single B, one rsp.
// - Error path: addr=0x4, slave returns bresp=10 -> rsp_resp=10 on the rsp_valid cycle.
// - Reset mid-WAIT_B: aresetn low 1 cycle -> all outputs 0, rr=0, no rsp_valid; next request served normally.
// - AXIL_WR_TIMEOUT_EN with TIMEOUT_CYCLES=16, m_bvalid never asserted
//     -> rsp_resp=11 and rsp_valid after 16 cycles, back in IDLE.

Source files
------------

// File: rtl/axi_lite_write_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite write port (AW/W/B) between NUM_REQ requesters.
// Latency: grant to rsp_valid is 3 cycles with a zero-stall slave; one transaction in flight.
// Backpressure: AW/W/B stalls simply hold the FSM; requesters wait until their req_ready pulse.
// Optional watchdog: define AXIL_WR_TIMEOUT_EN to abort stalled transactions with DECERR.
module axi_lite_write_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDRESS_SIZE   = 32,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]     req_data,
  input  logic [NUM_REQ*DATA_SIZE/8-1:0]   req_strb,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [1:0]                       rsp_resp,
  output logic [ADDRESS_SIZE-1:0]          m_awaddr,
  output logic                             m_awvalid,
  input  logic                             m_awready,
  output logic [DATA_SIZE-1:0]             m_wdata,
  output logic [DATA_SIZE/8-1:0]           m_wstrb,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  input  logic [1:0]                       m_bresp,
  input  logic                             m_bvalid,
  output logic                             m_bready
);

  localparam int STRB_W = DATA_SIZE / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject unsupported configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || (DATA_SIZE % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi_lite_write_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_B = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [IDX_W-1:0]          r_rr;
  logic [IDX_W-1:0]          r_gnt;
  logic [ADDRESS_SIZE-1:0]   r_awaddr;
  logic [DATA_SIZE-1:0]      r_wdata;
  logic [STRB_W-1:0]         r_wstrb;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_bready;
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [1:0]                r_rsp_resp;

  logic                      w_gnt_found;
  logic [IDX_W-1:0]          w_gnt_idx;
  logic [ADDRESS_SIZE-1:0]   w_sel_addr;
  logic [DATA_SIZE-1:0]      w_sel_data;
  logic [STRB_W-1:0]         w_sel_strb;
  logic                      w_grant_en;
  logic                      w_issue_done;
  logic                      w_b_done;
  logic                      w_abort;
  logic                      w_timeout;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_b_hs;
  logic [IDX_W-1:0]          w_rr_nxt;
  logic [NUM_REQ-1:0]        w_gnt_onehot;

  assign w_aw_hs      = r_awvalid && m_awready;
  assign w_w_hs       = r_wvalid && m_wready;
  assign w_b_hs       = r_bready && m_bvalid;
  assign w_rr_nxt     = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
  assign w_gnt_onehot = NUM_REQ'(1) << r_gnt;

  // Round-robin search starting at r_rr; also muxes the winner's payload.
  always_comb begin
    int k;
    k           = 0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_sel_strb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(r_rr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!w_gnt_found && req_valid[k[IDX_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = k[IDX_W-1:0];
        w_sel_addr  = req_addr[k*ADDRESS_SIZE +: ADDRESS_SIZE];
        w_sel_data  = req_data[k*DATA_SIZE +: DATA_SIZE];
        w_sel_strb  = req_strb[k*STRB_W +: STRB_W];
      end
    end
  end

`ifdef AXIL_WR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Watchdog: restarts on every grant, counts every cycle spent waiting on the slave.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_tmo_cnt <= '0;
    end else if (w_grant_en) begin
      r_tmo_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, transaction events and the combinational grant pulse.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_en   = 1'b0;
    w_issue_done = 1'b0;
    w_b_done     = 1'b0;
    w_abort      = 1'b0;
    req_ready    = '0;
    case (r_state)
      S_IDLE: begin
        if (aresetn && w_gnt_found) begin
          w_grant_en  = 1'b1;
          req_ready   = NUM_REQ'(1) << w_gnt_idx;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
          w_issue_done = 1'b1;
          w_state_nxt  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_b_hs) begin
          w_b_done    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on grant, drop AW/W valids on their own handshakes, report completion.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rr        <= '0;
      r_gnt       <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      r_rsp_valid <= '0;
      if (w_grant_en) begin
        r_gnt     <= w_gnt_idx;
        r_awaddr  <= w_sel_addr;
        r_wdata   <= w_sel_data;
        r_wstrb   <= w_sel_strb;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
      end else if (w_abort) begin
        // Stalled slave: drop every handshake and answer the requester with DECERR.
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_rsp_resp  <= 2'b11;
        r_rsp_valid <= w_gnt_onehot;
        r_rr        <= w_rr_nxt;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
        if (w_issue_done) r_bready <= 1'b1;
        if (w_b_done) begin
          r_bready    <= 1'b0;
          r_rsp_resp  <= m_bresp;
          r_rsp_valid <= w_gnt_onehot;
          r_rr        <= w_rr_nxt;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_resp  = r_rsp_resp;
  assign m_awaddr  = r_awaddr;
  assign m_awvalid = r_awvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Directed bench for axi_lite_write_arbiter with NUM_REQ=2 and hand-computed expectations.
// Inputs are driven 2 time units after the rising edge and outputs sampled 1 unit later.
// Watchdog scenario is exercised only when AXIL_WR_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_axi_lite_write_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              aclk;
  logic              aresetn;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR*DW/8-1:0] req_strb;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [AW-1:0]   exp_addr [NR];
  logic [DW-1:0]   exp_data [NR];
  logic [DW/8-1:0] exp_strb [NR];

  axi_lite_write_arbiter #(
    .NUM_REQ(NR), .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic load_reqs();
    req_addr = {exp_addr[1], exp_addr[0]};
    req_data = {exp_data[1], exp_data[0]};
    req_strb = {exp_strb[1], exp_strb[0]};
  endtask

  // One zero-stall transaction: called in the grant cycle, returns in the rsp_valid cycle.
  task automatic xact(input int g, input logic [1:0] resp, input logic [NR-1:0] hold);
    logic [NR-1:0] oh;
    oh = NR'(1) << g;
    #1 check("grant", req_ready, oh);
    step();
    req_valid = hold;
    #1;
    check("aw_w_valid", {m_awvalid, m_wvalid}, 2'b11);
    check("awaddr", m_awaddr, exp_addr[g]);
    check("wdata", m_wdata, exp_data[g]);
    check("wstrb", m_wstrb, exp_strb[g]);
    check("ready_once", req_ready, 0);
    check("bready_early", m_bready, 0);
    step();
    m_bvalid = 1'b1;
    m_bresp  = resp;
    #1;
    check("aw_w_done", {m_awvalid, m_wvalid}, 2'b00);
    check("bready", m_bready, 1);
    check("no_rsp_yet", rsp_valid, 0);
    step();
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    #1;
    check("rsp_valid", rsp_valid, oh);
    check("rsp_resp", rsp_resp, resp);
    check("bready_off", m_bready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "tb time limit");
  end

  initial begin
    aresetn   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_strb  = '0;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bresp   = 2'b00;
    m_bvalid  = 1'b0;

    // Reset state.
    step();
    step();
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_axi", {m_awvalid, m_wvalid, m_bready}, 3'b000);
    check("rst_awaddr", m_awaddr, 0);
    aresetn = 1'b1;
    step();

    // Single write from requester 0, OKAY.
    exp_addr[0] = 32'h0000_0000; exp_data[0] = 32'hDEAD_BEEF; exp_strb[0] = 4'hF;
    exp_addr[1] = 32'h0000_0200; exp_data[1] = 32'h1111_2222; exp_strb[1] = 4'h3;
    load_reqs();
    req_valid = 2'b01;
    xact(0, 2'b00, 2'b00);
    step();
    #1 check("rsp_pulse_end", rsp_valid, 0);

    // Error path: requester 1 to 0x4, slave answers SLVERR; rr now wraps back to 0.
    exp_addr[1] = 32'h0000_0004; exp_data[1] = 32'hCAFE_F00D; exp_strb[1] = 4'hC;
    load_reqs();
    req_valid = 2'b10;
    xact(1, 2'b10, 2'b00);
    step();
    #1 check("resp_hold", rsp_resp, 2'b10);

    // Contention from rr=0: strict rotation 0,1,0,1 with back-to-back grants.
    exp_addr[0] = 32'h0000_0100; exp_data[0] = 32'hA5A5_0001; exp_strb[0] = 4'h1;
    exp_addr[1] = 32'h0000_0200; exp_data[1] = 32'h5A5A_0002; exp_strb[1] = 4'h8;
    load_reqs();
    req_valid = 2'b11;
    xact(0, 2'b00, 2'b11);
    xact(1, 2'b00, 2'b11);
    xact(0, 2'b00, 2'b11);
    xact(1, 2'b00, 2'b00);
    step();
    #1;
    check("contention_idle_rsp", rsp_valid, 0);
    check("contention_idle_rdy", req_ready, 0);

    // Skewed handshake: W accepted at once, AW accepted four cycles later.
    m_awready = 1'b0;
    req_valid = 2'b01;
    #1 check("skew_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1 check("skew_both_valid", {m_awvalid, m_wvalid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("skew_w_first", {m_awvalid, m_wvalid}, 2'b10);
      check("skew_awaddr_stable", m_awaddr, 32'h0000_0100);
      check("skew_no_bready", m_bready, 0);
    end
    step();
    m_awready = 1'b1;
    #1 check("skew_aw_held", m_awvalid, 1);
    step();
    m_bvalid = 1'b1;
    m_bresp  = 2'b00;
    #1;
    check("skew_aw_done", m_awvalid, 0);
    check("skew_bready", m_bready, 1);
    step();
    m_bvalid = 1'b0;
    #1 check("skew_rsp", rsp_valid, 2'b01);
    step();
    #1 check("skew_single_rsp", rsp_valid, 0);

    // Reset while in WAIT_B: transaction from requester 1 (rr=1) is abandoned.
    exp_data[1] = 32'h0BAD_0BAD;
    load_reqs();
    req_valid = 2'b10;
    #1 check("rst_mid_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    #1 check("rst_mid_waitb", m_bready, 1);
    aresetn = 1'b0;
    step();
    #1;
    check("rst_mid_axi", {m_awvalid, m_wvalid, m_bready}, 3'b000);
    check("rst_mid_rsp", rsp_valid, 0);
    aresetn = 1'b1;
    step();
    #1 check("rst_mid_no_rsp", rsp_valid, 0);
    // rr must be back at 0, so requester 0 wins with both requesting.
    req_valid = 2'b11;
    xact(0, 2'b00, 2'b00);
    step();

`ifdef AXIL_WR_TIMEOUT_EN
    // Watchdog: slave never answers B; DECERR 16 cycles after entering ISSUE.
    req_valid = 2'b01;
    #1 check("tmo_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    for (int i = 1; i < 16; i++) step();
    #1;
    check("tmo_pending", m_bready, 1);
    check("tmo_no_rsp_yet", rsp_valid, 0);
    step();
    #1;
    check("tmo_rsp", rsp_valid, 2'b01);
    check("tmo_decerr", rsp_resp, 2'b11);
    check("tmo_axi_low", {m_awvalid, m_wvalid, m_bready}, 3'b000);
    m_bvalid = 1'b1;
    step();
    m_bvalid = 1'b0;
    #1 check("tmo_late_b_ignored", rsp_valid, 0);
    req_valid = 2'b10;
    #1 check("tmo_idle_grant", req_ready, 2'b10);
    req_valid = 2'b00;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
